// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-index width, control encodings and the
// destination-register select helper used at the ID/EX boundary.
package cpu_pkg;

  localparam int REG_W    = 5;
  localparam int ALU_OP_W = 4;

  typedef enum logic [1:0] {
    REG_DST_RT  = 2'b00,
    REG_DST_RD  = 2'b01,
    REG_DST_RA  = 2'b10,
    REG_DST_RSV = 2'b11
  } reg_dst_e;

  typedef enum logic [1:0] {
    MEM_TO_REG_ALU = 2'b00,
    MEM_TO_REG_MEM = 2'b01,
    MEM_TO_REG_PC4 = 2'b10,
    MEM_TO_REG_RSV = 2'b11
  } mem_to_reg_e;

  // Registered control bundle carried from ID into EX.
  typedef struct packed {
    logic                valid;
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                alu_src;
    logic [1:0]          mem_to_reg;
    logic [ALU_OP_W-1:0] alu_op;
  } ctrl_t;

  // Destination select; the reserved encoding falls back to Rt.
  function automatic logic [REG_W-1:0] resolve_dst(
    input logic [1:0]       reg_dst,
    input logic [REG_W-1:0] rt,
    input logic [REG_W-1:0] rd,
    input logic [REG_W-1:0] ra
  );
    logic [REG_W-1:0] dst;
    case (reg_dst_e'(reg_dst))
      REG_DST_RD: dst = rd;
      REG_DST_RA: dst = ra;
      default:    dst = rt;
    endcase
    return dst;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX bus: ID-stage operands/controls in, EX-stage registered values out,
// plus the PC / IF-ID write enables and the bubble/flush counters.
interface id_ex_stage_if
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);

  logic [DATA_WIDTH-1:0] i_pc_plus4, i_rs_data, i_rt_data, i_imm_ext;
  logic [REG_W-1:0]      i_Rs, i_Rt, i_Rd, i_shamt;
  logic                  i_uses_rs, i_uses_rt;
  logic                  i_reg_write, i_mem_read, i_mem_write, i_alu_src;
  logic [1:0]            i_mem_to_reg, i_reg_dst;
  logic [ALU_OP_W-1:0]   i_alu_op;
  logic                  i_valid, i_flush, i_stall_ext;

  logic [DATA_WIDTH-1:0] o_pc_plus4, o_rs_data, o_rt_data, o_imm_ext;
  logic [REG_W-1:0]      o_ID_EX_Rs, o_ID_EX_Rt, o_shamt, o_write_register_EX;
  logic                  o_reg_write, o_mem_read, o_mem_write, o_alu_src, o_valid;
  logic [1:0]            o_mem_to_reg;
  logic [ALU_OP_W-1:0]   o_alu_op;
  logic                  o_pc_write, o_IF_ID_write;
  logic [CNT_WIDTH-1:0]  o_bubble_count, o_flush_count;

  modport slave (
    input  i_pc_plus4, i_rs_data, i_rt_data, i_imm_ext,
    input  i_Rs, i_Rt, i_Rd, i_shamt, i_uses_rs, i_uses_rt,
    input  i_reg_write, i_mem_read, i_mem_write, i_alu_src,
    input  i_mem_to_reg, i_reg_dst, i_alu_op, i_valid, i_flush, i_stall_ext,
    output o_pc_plus4, o_rs_data, o_rt_data, o_imm_ext,
    output o_ID_EX_Rs, o_ID_EX_Rt, o_shamt, o_write_register_EX,
    output o_reg_write, o_mem_read, o_mem_write, o_alu_src, o_valid,
    output o_mem_to_reg, o_alu_op, o_pc_write, o_IF_ID_write,
    output o_bubble_count, o_flush_count
  );

  modport master (
    output i_pc_plus4, i_rs_data, i_rt_data, i_imm_ext,
    output i_Rs, i_Rt, i_Rd, i_shamt, i_uses_rs, i_uses_rt,
    output i_reg_write, i_mem_read, i_mem_write, i_alu_src,
    output i_mem_to_reg, i_reg_dst, i_alu_op, i_valid, i_flush, i_stall_ext,
    input  o_pc_plus4, o_rs_data, o_rt_data, o_imm_ext,
    input  o_ID_EX_Rs, o_ID_EX_Rt, o_shamt, o_write_register_EX,
    input  o_reg_write, o_mem_read, o_mem_write, o_alu_src, o_valid,
    input  o_mem_to_reg, o_alu_op, o_pc_write, o_IF_ID_write,
    input  o_bubble_count, o_flush_count
  );

endinterface

// File: rtl/load_use_detect.sv
// Load-use hazard: the load sitting in EX writes a register that the ID
// instruction actually reads. Writes to $0 never create a dependency.
module load_use_detect
  import cpu_pkg::*;
(
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_wr_reg,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  output logic             load_use
);

  logic ex_is_load;
  logic rs_hit;
  logic rt_hit;

  assign ex_is_load = ex_valid & ex_mem_read & (ex_wr_reg != '0);
  assign rs_hit     = id_uses_rs & (id_rs == ex_wr_reg);
  assign rt_hit     = id_uses_rt & (id_rt == ex_wr_reg);
  assign load_use   = ex_is_load & (rs_hit | rt_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush squashing,
// external-stall hold and saturating bubble/flush counters.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int               DATA_WIDTH = 32,
  parameter int               CNT_WIDTH  = 16,
  parameter logic [REG_W-1:0] RA_REG     = 5'd31
) (
  input logic          i_clk,
  input logic          i_rst,
  id_ex_stage_if.slave bus
);

  logic [DATA_WIDTH-1:0] pc4_q, pc4_d, rs_data_q, rs_data_d;
  logic [DATA_WIDTH-1:0] rt_data_q, rt_data_d, imm_q, imm_d;
  logic [REG_W-1:0]      rs_q, rs_d, rt_q, rt_d, shamt_q, shamt_d, wr_q, wr_d;
  ctrl_t                 ctrl_q, ctrl_d;
  logic [CNT_WIDTH-1:0]  bubble_cnt_q, bubble_cnt_d, flush_cnt_q, flush_cnt_d;

  logic load_use;
  logic load_bubble;
  logic capture;
  logic front_write;

  load_use_detect u_load_use_detect (
    .ex_valid    (ctrl_q.valid),
    .ex_mem_read (ctrl_q.mem_read),
    .ex_wr_reg   (wr_q),
    .id_rs       (bus.i_Rs),
    .id_rt       (bus.i_Rt),
    .id_uses_rs  (bus.i_uses_rs),
    .id_uses_rt  (bus.i_uses_rt),
    .load_use    (load_use)
  );

  // Per-cycle action: stall beats flush, flush beats load-use.
  always_comb begin
    load_bubble  = 1'b0;
    capture      = 1'b0;
    front_write  = 1'b1;
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (bus.i_stall_ext) begin
      front_write = 1'b0;
    end else if (bus.i_flush) begin
      load_bubble = 1'b1;
      if (flush_cnt_q != {CNT_WIDTH{1'b1}}) flush_cnt_d = flush_cnt_q + 1'b1;
    end else if (load_use) begin
      load_bubble = 1'b1;
      front_write = 1'b0;
      if (bubble_cnt_q != {CNT_WIDTH{1'b1}}) bubble_cnt_d = bubble_cnt_q + 1'b1;
    end else begin
      capture = 1'b1;
    end
  end

  // Next pipeline contents: hold, all-zero bubble, or the ID instruction.
  always_comb begin
    pc4_d     = pc4_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    shamt_d   = shamt_q;
    wr_d      = wr_q;
    ctrl_d    = ctrl_q;
    if (load_bubble) begin
      pc4_d     = '0;
      rs_data_d = '0;
      rt_data_d = '0;
      imm_d     = '0;
      rs_d      = '0;
      rt_d      = '0;
      shamt_d   = '0;
      wr_d      = '0;
      ctrl_d    = '0;
    end else if (capture) begin
      pc4_d             = bus.i_pc_plus4;
      rs_data_d         = bus.i_rs_data;
      rt_data_d         = bus.i_rt_data;
      imm_d             = bus.i_imm_ext;
      rs_d              = bus.i_Rs;
      rt_d              = bus.i_Rt;
      shamt_d           = bus.i_shamt;
      wr_d              = resolve_dst(bus.i_reg_dst, bus.i_Rt, bus.i_Rd, RA_REG);
      ctrl_d.valid      = bus.i_valid;
      // An empty slot must never commit architectural state.
      ctrl_d.reg_write  = bus.i_reg_write & bus.i_valid;
      ctrl_d.mem_write  = bus.i_mem_write & bus.i_valid;
      ctrl_d.mem_read   = bus.i_mem_read;
      ctrl_d.alu_src    = bus.i_alu_src;
      ctrl_d.mem_to_reg = bus.i_mem_to_reg;
      ctrl_d.alu_op     = bus.i_alu_op;
    end
  end

  // Pipeline and counter state, cleared asynchronously.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pc4_q        <= '0;
      rs_data_q    <= '0;
      rt_data_q    <= '0;
      imm_q        <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      shamt_q      <= '0;
      wr_q         <= '0;
      ctrl_q       <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      pc4_q        <= pc4_d;
      rs_data_q    <= rs_data_d;
      rt_data_q    <= rt_data_d;
      imm_q        <= imm_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      shamt_q      <= shamt_d;
      wr_q         <= wr_d;
      ctrl_q       <= ctrl_d;
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign bus.o_pc_plus4          = pc4_q;
  assign bus.o_rs_data           = rs_data_q;
  assign bus.o_rt_data           = rt_data_q;
  assign bus.o_imm_ext           = imm_q;
  assign bus.o_ID_EX_Rs          = rs_q;
  assign bus.o_ID_EX_Rt          = rt_q;
  assign bus.o_shamt             = shamt_q;
  assign bus.o_write_register_EX = wr_q;
  assign bus.o_valid             = ctrl_q.valid;
  assign bus.o_reg_write         = ctrl_q.reg_write;
  assign bus.o_mem_read          = ctrl_q.mem_read;
  assign bus.o_mem_write         = ctrl_q.mem_write;
  assign bus.o_alu_src           = ctrl_q.alu_src;
  assign bus.o_mem_to_reg        = ctrl_q.mem_to_reg;
  assign bus.o_alu_op            = ctrl_q.alu_op;
  assign bus.o_pc_write          = front_write;
  assign bus.o_IF_ID_write       = front_write;
  assign bus.o_bubble_count      = bubble_cnt_q;
  assign bus.o_flush_count       = flush_cnt_q;

endmodule
